// File: rtl/shifter_arbiter_ctrl_pkg.sv
// Shared definitions for the shifter arbiter controller.
//   state_t  : controller FSM states (IDLE, ST1, ST2, RESP)
//   ID_ALIGN : requester id of the alignment path (response id 0)
//   ID_NORM  : requester id of the normalization path (response id 1)
package shifter_arbiter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ST1  = 2'd1,
    ST2  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic ID_ALIGN = 1'b0;
  localparam logic ID_NORM  = 1'b1;

endpackage

// File: rtl/shift_rr_arbiter.sv
// Two-way round-robin arbiter between the alignment and normalization
// requesters of the shared two-stage shifter.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   req_align    : alignment requester is valid
//   req_norm     : normalization requester is valid
//   accept       : the current grant is taken this cycle (updates pointer)
//   gnt_vld      : some requester is granted
//   gnt_id       : granted requester (ID_ALIGN / ID_NORM)
module shift_rr_arbiter
  import shifter_arbiter_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_align,
  input  logic req_norm,
  input  logic accept,
  output logic gnt_vld,
  output logic gnt_id
);

  logic last_id;

  // A tie goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    gnt_vld = req_align | req_norm;
    if (req_align && req_norm) begin
      gnt_id = ~last_id;
    end else if (req_norm) begin
      gnt_id = ID_NORM;
    end else begin
      gnt_id = ID_ALIGN;
    end
  end

  // Resetting to ID_ALIGN makes normalization win the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_id <= ID_ALIGN;
    end else if (accept) begin
      last_id <= gnt_id;
    end
  end

endmodule

// File: rtl/shifter_arbiter_ctrl.sv
// Shares one two-stage barrel shifter between the alignment (id 0) and
// normalization (id 1) requesters. One operation at a time, fixed latency:
// accept at T, shifter load at T+1, capture at T+2, response from T+3.
// Ports:
//   clk, rst                       : clock, synchronous active-low reset
//   al_valid_i / al_ready_o        : alignment request handshake
//   al_data_i, al_shift_i,
//   al_left_right_i, al_fill_i     : alignment operand, amount, dir, fill
//   nm_*                           : same set for the normalization requester
//   sh_load_o, sh_data_o,
//   sh_left_right_o,
//   sh_shift_value_o, sh_bit_shift_o : drive to the shifter inputs
//   sh_load_i, sh_data_i           : shifter load_o / Data_o
//   rsp_valid_o, rsp_id_o,
//   rsp_data_o / rsp_ready_i       : response handshake
//   busy_o                         : an operation is in flight
//   err_o                          : sticky "shifter did not flag result" error
module shifter_arbiter_ctrl
  import shifter_arbiter_ctrl_pkg::*;
#(
  parameter int SWR = 26,
  parameter int EWR = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           al_valid_i,
  output logic           al_ready_o,
  input  logic [SWR-1:0] al_data_i,
  input  logic [EWR-1:0] al_shift_i,
  input  logic           al_left_right_i,
  input  logic           al_fill_i,
  input  logic           nm_valid_i,
  output logic           nm_ready_o,
  input  logic [SWR-1:0] nm_data_i,
  input  logic [EWR-1:0] nm_shift_i,
  input  logic           nm_left_right_i,
  input  logic           nm_fill_i,
  output logic           sh_load_o,
  output logic [SWR-1:0] sh_data_o,
  output logic           sh_left_right_o,
  output logic [EWR-1:0] sh_shift_value_o,
  output logic           sh_bit_shift_o,
  input  logic           sh_load_i,
  input  logic [SWR-1:0] sh_data_i,
  output logic           rsp_valid_o,
  output logic           rsp_id_o,
  output logic [SWR-1:0] rsp_data_o,
  input  logic           rsp_ready_i,
  output logic           busy_o,
  output logic           err_o
);

  state_t         state;
  logic           gnt_vld;
  logic           gnt_id;
  logic           accept;

  logic [SWR-1:0] data_p0;
  logic [EWR-1:0] shift_p0;
  logic           lr_p0;
  logic           fill_p0;
  logic           id_p0;
  logic [SWR-1:0] rsp_data_p1;
  logic           err_q;

  shift_rr_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_align (al_valid_i),
    .req_norm  (nm_valid_i),
    .accept    (accept),
    .gnt_vld   (gnt_vld),
    .gnt_id    (gnt_id)
  );

  // Gated by rst so nothing is offered during a reset cycle.
  assign accept     = rst && (state == IDLE) && gnt_vld;
  assign al_ready_o = accept && (gnt_id == ID_ALIGN);
  assign nm_ready_o = accept && (gnt_id == ID_NORM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      data_p0     <= '0;
      shift_p0    <= '0;
      lr_p0       <= 1'b0;
      fill_p0     <= 1'b0;
      id_p0       <= ID_ALIGN;
      rsp_data_p1 <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state)
        // Stage 0: latch the granted request
        IDLE: begin
          if (accept) begin
            data_p0  <= gnt_id ? nm_data_i       : al_data_i;
            shift_p0 <= gnt_id ? nm_shift_i      : al_shift_i;
            lr_p0    <= gnt_id ? nm_left_right_i : al_left_right_i;
            fill_p0  <= gnt_id ? nm_fill_i       : al_fill_i;
            id_p0    <= gnt_id;
            state    <= ST1;
          end
        end
        // Stage 1: shifter loads the latched operand
        ST1: state <= ST2;
        // Stage 2: capture shifter result; a missing load_o is a protocol error
        ST2: begin
          rsp_data_p1 <= sh_data_i;
          if (!sh_load_i) begin
            err_q <= 1'b1;
          end
          state <= RESP;
        end
        // Stage 3: hold response until consumed
        RESP: begin
          if (rsp_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The latches only change on acceptance, so the shifter controls stay
  // steady through ST2 and hold their last values while idle.
  assign sh_load_o        = (state == ST1);
  assign sh_data_o        = data_p0;
  assign sh_left_right_o  = lr_p0;
  assign sh_shift_value_o = shift_p0;
  assign sh_bit_shift_o   = fill_p0;

  assign rsp_valid_o = (state == RESP);
  assign rsp_id_o    = id_p0;
  assign rsp_data_o  = rsp_data_p1;
  assign busy_o      = (state != IDLE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_shifter_arbiter_ctrl.sv
module tb_shifter_arbiter_ctrl;

  localparam int SWR = 26;
  localparam int EWR = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           al_valid_i = 1'b0;
  logic           al_ready_o;
  logic [SWR-1:0] al_data_i = '0;
  logic [EWR-1:0] al_shift_i = '0;
  logic           al_left_right_i = 1'b0;
  logic           al_fill_i = 1'b0;
  logic           nm_valid_i = 1'b0;
  logic           nm_ready_o;
  logic [SWR-1:0] nm_data_i = '0;
  logic [EWR-1:0] nm_shift_i = '0;
  logic           nm_left_right_i = 1'b0;
  logic           nm_fill_i = 1'b0;
  logic           sh_load_o;
  logic [SWR-1:0] sh_data_o;
  logic           sh_left_right_o;
  logic [EWR-1:0] sh_shift_value_o;
  logic           sh_bit_shift_o;
  logic           sh_load_i = 1'b0;
  logic [SWR-1:0] sh_data_i = '0;
  logic           rsp_valid_o;
  logic           rsp_id_o;
  logic [SWR-1:0] rsp_data_o;
  logic           rsp_ready_i = 1'b1;
  logic           busy_o;
  logic           err_o;

  logic           drop_load = 1'b0;
  int             n_assert = 0;
  int             n_fail = 0;

  shifter_arbiter_ctrl #(.SWR(SWR), .EWR(EWR)) dut (
    .clk(clk), .rst(rst),
    .al_valid_i(al_valid_i), .al_ready_o(al_ready_o), .al_data_i(al_data_i),
    .al_shift_i(al_shift_i), .al_left_right_i(al_left_right_i), .al_fill_i(al_fill_i),
    .nm_valid_i(nm_valid_i), .nm_ready_o(nm_ready_o), .nm_data_i(nm_data_i),
    .nm_shift_i(nm_shift_i), .nm_left_right_i(nm_left_right_i), .nm_fill_i(nm_fill_i),
    .sh_load_o(sh_load_o), .sh_data_o(sh_data_o), .sh_left_right_o(sh_left_right_o),
    .sh_shift_value_o(sh_shift_value_o), .sh_bit_shift_o(sh_bit_shift_o),
    .sh_load_i(sh_load_i), .sh_data_i(sh_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o),
    .rsp_ready_i(rsp_ready_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Two-stage shifter stand-in: result and load_o one cycle after load_i.
  function automatic logic [SWR-1:0] model_shift(input logic [SWR-1:0] d,
      input logic [EWR-1:0] s, input logic lr, input logic f);
    logic [SWR-1:0] o;
    for (int i = 0; i < SWR; i++) begin
      int src;
      src = lr ? i - int'(s) : i + int'(s);
      o[i] = (src >= 0 && src < SWR) ? d[src] : f;
    end
    return o;
  endfunction

  always @(posedge clk) begin
    sh_load_i <= sh_load_o & ~drop_load;
    if (sh_load_o)
      sh_data_i <= model_shift(sh_data_o, sh_shift_value_o, sh_left_right_o, sh_bit_shift_o);
  end

  // Reference result from plain shift arithmetic.
  function automatic logic [SWR-1:0] ref_shift(input logic [SWR-1:0] d,
      input logic [EWR-1:0] s, input logic lr, input logic f);
    logic [63:0] m, w, r;
    int n;
    m = (64'd1 << SWR) - 64'd1;
    w = 64'(d);
    n = int'(s);
    if (lr) r = (w << n) | (f ? ((64'd1 << n) - 64'd1) : 64'd0);
    else    r = (w >> n) | (f ? (m & ~(m >> n)) : 64'd0);
    return SWR'(r & m);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and returns in the RESP cycle (T+3).
  task automatic do_op(input logic id, input logic [SWR-1:0] d, input logic [EWR-1:0] s,
      input logic lr, input logic f);
    if (id) begin
      nm_valid_i = 1'b1; nm_data_i = d; nm_shift_i = s; nm_left_right_i = lr; nm_fill_i = f;
    end else begin
      al_valid_i = 1'b1; al_data_i = d; al_shift_i = s; al_left_right_i = lr; al_fill_i = f;
    end
    #1;
    chk("op_ready", 64'(id ? nm_ready_o : al_ready_o), 64'd1);
    cyc();
    al_valid_i = 1'b0;
    nm_valid_i = 1'b0;
    cyc();
    cyc();
  endtask

  logic [SWR-1:0] s1_shift_rec;
  logic           s1_lr_rec;
  logic           m_idle, m_last, m_id, e_al, e_nm, e_rv;
  int             m_age;
  logic [SWR-1:0] m_data;

  initial begin
    // Reset state, with a request pending during reset
    rst = 1'b0;
    al_valid_i = 1'b1;
    al_data_i = 26'h1234567;
    cyc();
    cyc();
    chk("rst_al_ready", 64'(al_ready_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_sh_load", 64'(sh_load_o), 64'd0);
    chk("rst_sh_data", 64'(sh_data_o), 64'd0);
    chk("rst_sh_shift", 64'(sh_shift_value_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data_o), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id_o), 64'd0);
    al_valid_i = 1'b0;

    // Single align, right shift by 4
    rst = 1'b1;
    rsp_ready_i = 1'b1;
    al_valid_i = 1'b1; al_data_i = 26'h0000F00; al_shift_i = 5'd4;
    al_left_right_i = 1'b0; al_fill_i = 1'b0;
    #1;
    chk("single_al_ready", 64'(al_ready_o), 64'd1);
    chk("single_nm_ready", 64'(nm_ready_o), 64'd0);
    cyc();
    al_valid_i = 1'b0;
    chk("single_t1_load", 64'(sh_load_o), 64'd1);
    chk("single_t1_data", 64'(sh_data_o), 64'h0000F00);
    chk("single_t1_shift", 64'(sh_shift_value_o), 64'd4);
    chk("single_t1_busy", 64'(busy_o), 64'd1);
    cyc();
    chk("single_t2_load", 64'(sh_load_o), 64'd0);
    chk("single_t2_rv", 64'(rsp_valid_o), 64'd0);
    cyc();
    chk("single_t3_rv", 64'(rsp_valid_o), 64'd1);
    chk("single_t3_data", 64'(rsp_data_o), 64'h00000F0);
    chk("single_t3_id", 64'(rsp_id_o), 64'd0);
    cyc();
    chk("single_idle", 64'(busy_o), 64'd0);
    chk("single_rv_drop", 64'(rsp_valid_o), 64'd0);

    // Tie from reset: norm first, then align
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    al_valid_i = 1'b1; al_data_i = 26'h0000001; al_shift_i = 5'd3;
    al_left_right_i = 1'b1; al_fill_i = 1'b1;
    nm_valid_i = 1'b1; nm_data_i = 26'h2AAAAAA; nm_shift_i = 5'd1;
    nm_left_right_i = 1'b0; nm_fill_i = 1'b1;
    #1;
    chk("tie_nm_ready", 64'(nm_ready_o), 64'd1);
    chk("tie_al_ready", 64'(al_ready_o), 64'd0);
    cyc();
    nm_valid_i = 1'b0;
    chk("tie_st1_al_ready", 64'(al_ready_o), 64'd0);
    cyc();
    cyc();
    chk("tie_rsp1_id", 64'(rsp_id_o), 64'd1);
    chk("tie_rsp1_data", 64'(rsp_data_o), 64'h3555555);
    cyc();
    chk("tie_al_ready2", 64'(al_ready_o), 64'd1);
    cyc();
    al_valid_i = 1'b0;
    cyc();
    cyc();
    chk("tie_rsp2_rv", 64'(rsp_valid_o), 64'd1);
    chk("tie_rsp2_id", 64'(rsp_id_o), 64'd0);
    chk("tie_rsp2_data", 64'(rsp_data_o), 64'h000000F);
    cyc();

    // Backpressure: response held for 10 cycles while both requesters wait
    rsp_ready_i = 1'b0;
    do_op(1'b0, 26'h3FFFFFF, 5'd0, 1'b0, 1'b0);
    al_valid_i = 1'b1; al_data_i = 26'h0000010;
    nm_valid_i = 1'b1; nm_data_i = 26'h0000020;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rv", 64'(rsp_valid_o), 64'd1);
      chk("bp_data", 64'(rsp_data_o), 64'h3FFFFFF);
      chk("bp_al_ready", 64'(al_ready_o), 64'd0);
      chk("bp_nm_ready", 64'(nm_ready_o), 64'd0);
      cyc();
    end
    rsp_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", 64'(al_ready_o | nm_ready_o), 64'd0);
    cyc();
    chk("bp_idle", 64'(busy_o), 64'd0);
    chk("bp_rr_nm", 64'(nm_ready_o), 64'd1);
    chk("bp_rr_al", 64'(al_ready_o), 64'd0);
    al_valid_i = 1'b0;
    nm_valid_i = 1'b0;
    cyc();

    // Hold check: left shift of 1 by 19
    al_valid_i = 1'b1; al_data_i = 26'h0000001; al_shift_i = 5'd19;
    al_left_right_i = 1'b1; al_fill_i = 1'b0;
    #1;
    chk("hold_ready", 64'(al_ready_o), 64'd1);
    cyc();
    al_valid_i = 1'b0;
    s1_shift_rec = SWR'(sh_shift_value_o);
    s1_lr_rec = sh_left_right_o;
    chk("hold_st1_load", 64'(sh_load_o), 64'd1);
    cyc();
    chk("hold_st2_load", 64'(sh_load_o), 64'd0);
    chk("hold_st2_shift_vs_st1", 64'(sh_shift_value_o), 64'(s1_shift_rec));
    chk("hold_st2_lr_vs_st1", 64'(sh_left_right_o), 64'(s1_lr_rec));
    chk("hold_st2_shift", 64'(sh_shift_value_o), 64'd19);
    chk("hold_st2_lr", 64'(sh_left_right_o), 64'd1);
    cyc();
    chk("hold_rsp_data", 64'(rsp_data_o), 64'h0080000);
    cyc();

    // Shifter drops load_o -> sticky error
    chk("err_before", 64'(err_o), 64'd0);
    drop_load = 1'b1;
    do_op(1'b1, 26'h0000123, 5'd0, 1'b0, 1'b0);
    chk("err_set", 64'(err_o), 64'd1);
    chk("err_data_captured", 64'(rsp_data_o), 64'h0000123);
    cyc();
    drop_load = 1'b0;
    do_op(1'b0, 26'h0000456, 5'd4, 1'b1, 1'b0);
    chk("err_sticky", 64'(err_o), 64'd1);
    chk("err_next_data", 64'(rsp_data_o), 64'h0004560);
    cyc();
    chk("err_sticky_idle", 64'(err_o), 64'd1);
    rst = 1'b0;
    cyc();
    chk("err_cleared", 64'(err_o), 64'd0);
    rst = 1'b1;

    // Reset during ST2 drops the operation
    al_valid_i = 1'b1; al_data_i = 26'h0ABCDEF; al_shift_i = 5'd2;
    al_left_right_i = 1'b0; al_fill_i = 1'b0;
    #1;
    chk("rst2_accept", 64'(al_ready_o), 64'd1);
    cyc();
    al_valid_i = 1'b0;
    cyc();
    chk("rst2_in_st2", 64'(busy_o), 64'd1);
    rst = 1'b0;
    al_valid_i = 1'b1;
    #1;
    chk("rst2_ready_low", 64'(al_ready_o), 64'd0);
    cyc();
    chk("rst2_busy", 64'(busy_o), 64'd0);
    chk("rst2_sh_load", 64'(sh_load_o), 64'd0);
    chk("rst2_sh_data", 64'(sh_data_o), 64'd0);
    chk("rst2_rv", 64'(rsp_valid_o), 64'd0);
    chk("rst2_rsp_data", 64'(rsp_data_o), 64'd0);
    rst = 1'b1;
    al_valid_i = 1'b0;
    cyc();
    chk("rst2_no_rsp", 64'(rsp_valid_o), 64'd0);
    do_op(1'b0, 26'h0ABCDEF, 5'd2, 1'b0, 1'b0);
    chk("rst2_new_rv", 64'(rsp_valid_o), 64'd1);
    chk("rst2_new_data", 64'(rsp_data_o), 64'h02AF37B);
    cyc();

    // Randomized traffic against the reference model
    m_idle = 1'b1; m_age = 0; m_last = 1'b0; m_id = 1'b0; m_data = '0;
    for (int c = 0; c < 400; c++) begin
      if (!al_valid_i && $urandom_range(0, 2) == 0) begin
        al_valid_i = 1'b1; al_data_i = SWR'($urandom()); al_shift_i = EWR'($urandom());
        al_left_right_i = 1'($urandom_range(0, 1)); al_fill_i = 1'($urandom_range(0, 1));
      end
      if (!nm_valid_i && $urandom_range(0, 2) == 0) begin
        nm_valid_i = 1'b1; nm_data_i = SWR'($urandom()); nm_shift_i = EWR'($urandom());
        nm_left_right_i = 1'($urandom_range(0, 1)); nm_fill_i = 1'($urandom_range(0, 1));
      end
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      e_al = m_idle && al_valid_i && (!nm_valid_i || m_last);
      e_nm = m_idle && nm_valid_i && (!al_valid_i || !m_last);
      e_rv = !m_idle && (m_age >= 3);
      chk("rnd_al_ready", 64'(al_ready_o), 64'(e_al));
      chk("rnd_nm_ready", 64'(nm_ready_o), 64'(e_nm));
      chk("rnd_rsp_valid", 64'(rsp_valid_o), 64'(e_rv));
      chk("rnd_busy", 64'(busy_o), 64'(!m_idle));
      chk("rnd_sh_load", 64'(sh_load_o), 64'(!m_idle && m_age == 1));
      if (e_rv) begin
        chk("rnd_rsp_id", 64'(rsp_id_o), 64'(m_id));
        chk("rnd_rsp_data", 64'(rsp_data_o), 64'(m_data));
      end
      if (e_rv && rsp_ready_i) begin
        m_idle = 1'b1;
      end else if (e_al || e_nm) begin
        m_idle = 1'b0;
        m_age = 0;
        m_last = e_nm;
        m_id = e_nm;
        m_data = e_nm ? ref_shift(nm_data_i, nm_shift_i, nm_left_right_i, nm_fill_i)
                      : ref_shift(al_data_i, al_shift_i, al_left_right_i, al_fill_i);
      end
      cyc();
      if (e_al) al_valid_i = 1'b0;
      if (e_nm) nm_valid_i = 1'b0;
      if (!m_idle) m_age++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/shifter_arbiter_ctrl.md
SHIFTER_ARBITER_CTRL -- requirements
Module: shifter_arbiter_ctrl

Interface
REQ-001 The block SHALL have parameter SWR, default 26, giving the mantissa datapath width in bits.
REQ-002 The block SHALL have parameter EWR, default 5, giving the shift-amount width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port al_valid_i, input, 1 bit: alignment requester has a shift request.
REQ-006 The block SHALL have port al_ready_o, output, 1 bit: alignment request accepted this cycle.
REQ-007 The block SHALL have ports al_data_i [SWR], al_shift_i [EWR], al_left_right_i [1] and al_fill_i [1], inputs: alignment operand, shift amount, direction and fill bit.
REQ-008 The block SHALL have ports nm_valid_i, nm_ready_o, nm_data_i, nm_shift_i, nm_left_right_i and nm_fill_i, with the same widths and meanings as the al_* ports, for the normalization requester.
REQ-009 The block SHALL have ports sh_load_o [1], sh_data_o [SWR], sh_left_right_o [1], sh_shift_value_o [EWR] and sh_bit_shift_o [1], outputs: drive for the two-stage shifter's load_i, Data_i, FSM_left_right_i, Shift_Value_i and bit_shift_i.
REQ-010 The block SHALL have ports sh_load_i [1] and sh_data_i [SWR], inputs: the shifter's load_o and Data_o.
REQ-011 The block SHALL have ports rsp_valid_o [1], rsp_id_o [1], rsp_data_o [SWR], outputs, and rsp_ready_i [1], input: the response handshake, where rsp_id_o is 0 for alignment and 1 for normalization.
REQ-012 The block SHALL have ports busy_o [1] and err_o [1], outputs: busy_o is high whenever state is not IDLE; err_o is a sticky shifter protocol error.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, ST1, ST2 and RESP.
REQ-014 In IDLE, the ready signal of the granted requester SHALL be high, and all other ready signals SHALL be low.
  - On a valid handshake, the block SHALL latch data, shift, direction, fill and id into internal registers, then move to ST1.
REQ-015 Arbitration SHALL be round-robin.
  - When only one requester is valid, that requester SHALL be granted.
  - When both are valid, the requester not granted last SHALL be granted.
  - After reset, the last-grant pointer SHALL equal alignment, so normalization wins the first tie.
REQ-016 In ST1, sh_load_o SHALL be 1 for exactly one cycle, with all sh_* outputs driven from the latched registers; the FSM SHALL then move to ST2.
REQ-017 In ST2, sh_load_o SHALL be 0, and sh_left_right_o, sh_shift_value_o and sh_bit_shift_o SHALL hold their ST1 values (the second shifter stage and the output rotate consume them).
  - sh_data_i SHALL be captured into rsp_data_o, and the FSM SHALL move to RESP.
REQ-018 If sh_load_i is 0 in ST2, err_o SHALL be set, and the data SHALL still be captured.
  - err_o SHALL clear only on reset.
REQ-019 In RESP, rsp_valid_o SHALL be 1, and rsp_data_o and rsp_id_o SHALL be stable until the cycle in which rsp_ready_i is 1.
  - In that cycle, the FSM SHALL move to IDLE.
REQ-020 Latency SHALL be fixed: request accepted at cycle T, sh_load_o at T+1, capture at T+2, rsp_valid_o from T+3.
  - Throughput SHALL be at most one operation per 4 cycles.
REQ-021 Outside ST1/ST2, sh_load_o SHALL be 0, and the other sh_* outputs SHALL hold their last values (no toggling).
REQ-022 Shift amounts SHALL be passed to the shifter unmodified; any value from 0 to 2^EWR-1 is legal.
REQ-023 Requests arriving while not in IDLE SHALL see ready=0 and SHALL NOT be lost or reordered; requesters hold valid.
REQ-024 A simultaneous rsp_ready_i and new requests in RESP SHALL give RESP->IDLE; arbitration then happens in the next cycle.

Reset
REQ-025 While rst=0 at a clock edge, the following SHALL hold:
  - state=IDLE;
  - all of sh_*_o, rsp_valid_o, rsp_id_o, rsp_data_o, busy_o and err_o = 0;
  - last-grant pointer = alignment;
  - the latched request = 0.
REQ-026 A reset during ST1, ST2 or RESP SHALL drop the operation with no response; ready SHALL be low during the reset cycle.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, ST1, ST2, RESP) and the constants ID_ALIGN=0 and ID_NORM=1.
REQ-028 The two-way round-robin grant logic with its pointer SHALL be one sub-module, shift_rr_arbiter.
  - The FSM, latches and response register SHALL remain in shifter_arbiter_ctrl.

Verification
REQ-029 Single align: al_data=26'h0000F00, shift=4, right, fill=0, with a shifter model -> sh_load_o pulses at T+1; rsp_valid at T+3 with data 26'h00000F0 and id=0.
REQ-030 Tie: both valid from reset -> the norm request is served first (id=1), then the align request (id=0); each takes 4 cycles with rsp_ready held at 1.
REQ-031 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and data stay stable, and both ready signals stay 0; then rsp_ready=1 -> IDLE the next cycle.
REQ-032 Hold check: in ST2, sh_shift_value_o=5'd19 and sh_left_right_o=1 equal their ST1 values; left shift of 26'h1 by 19 -> 26'h0080000.
REQ-033 The shifter model drops load_o in ST2 -> err_o=1, stays 1 across later operations, and clears only on rst=0.
REQ-034 rst=0 asserted in ST2 -> the next cycle shows IDLE, all outputs 0, and no response; a new request is then accepted normally.
